// File: rtl/router_ingress_fifo_if.sv
// Ingress handshake and router-facing bundle for router_ingress_fifo.
// master = upstream/router side, slave = the FIFO itself.
interface router_ingress_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [1:0]            in_addr;
  logic [3:0]            port_busy;
  logic [DATA_WIDTH-1:0] din;
  logic                  din_en;
  logic [1:0]            addr;
  logic [CNT_W-1:0]      count;
  logic                  hol_block;

  modport master (
    output in_valid, in_data, in_addr, port_busy,
    input  in_ready, din, din_en, addr, count, hol_block
  );

  modport slave (
    input  in_valid, in_data, in_addr, port_busy,
    output in_ready, din, din_en, addr, count, hol_block
  );
endinterface

// File: rtl/router_ingress_fifo.sv
// In-order ingress FIFO feeding a 4-port router; the head entry is issued
// only when its destination port is not busy, blocking everything behind it.
module router_ingress_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input logic                 clk,
  input logic                 rst,
  router_ingress_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH+1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [1:0]            addr_q;
  logic                  din_en_q;

  logic [DATA_WIDTH+1:0] head;
  logic [1:0]            head_addr;
  logic                  head_busy;
  logic                  not_empty;
  logic                  in_ready;
  logic                  push;
  logic                  pop;

  assign head      = mem[rd_ptr];
  assign head_addr = head[DATA_WIDTH+1:DATA_WIDTH];
  assign not_empty = (count_q != '0);
  assign head_busy = bus.port_busy[head_addr];
  // in_ready comes from the registered count only, so a full FIFO never
  // accepts in the same cycle it pops.
  assign in_ready  = (count_q < FULL_CNT);
  assign push      = bus.in_valid && in_ready;
  assign pop       = not_empty && !head_busy;

  // Storage is not reset; entries are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {bus.in_addr, bus.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      din_en_q <= 1'b0;
      din_q    <= '0;
      addr_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      din_en_q <= pop;
      din_q    <= pop ? head[DATA_WIDTH-1:0] : '0;
      addr_q   <= pop ? head_addr : 2'd0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.din       = din_q;
  assign bus.din_en    = din_en_q;
  assign bus.addr      = addr_q;
  assign bus.count     = count_q;
  assign bus.hol_block = not_empty && head_busy;
endmodule

// File: tb/tb_router_ingress_fifo.sv
// Self-checking bench for router_ingress_fifo: directed cases plus an
// in-order scoreboard fed from accepted beats and drained on din_en.
module tb_router_ingress_fifo;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 8;

  logic clk;
  logic rst;

  router_ingress_fifo_if #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus ();

  router_ingress_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [33:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle monitor, sampled mid-cycle: drain scoreboard, check idle
  // outputs and occupancy bound, then record the beat the next edge takes.
  always @(negedge clk) begin
    logic [33:0] e;
    if (bus.din_en) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", bus.din, e[31:0]);
        chk("sb_addr", 32'(bus.addr), 32'(e[33:32]));
      end
    end else begin
      chk("idle_din", bus.din, 32'd0);
      chk("idle_addr", 32'(bus.addr), 32'd0);
    end
    chk("count_max", 32'(bus.count <= 4'(DEPTH)), 32'd1);
    if (rst) exp_q.delete();
    else if (bus.in_valid && bus.in_ready) exp_q.push_back({bus.in_addr, bus.in_data});
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_addr   = '0;
    bus.port_busy = 4'b0000;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_hol", 32'(bus.hol_block), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_din_en", 32'(bus.din_en), 32'd0);

    // Minimum latency: push at E, pop at E+1, din_en in the cycle after.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hA5A5_0001;
    bus.in_addr  = 2'd2;
    step();
    bus.in_valid = 1'b0;
    chk("lat_count1", 32'(bus.count), 32'd1);
    chk("lat_early", 32'(bus.din_en), 32'd0);
    step();
    chk("lat_din_en", 32'(bus.din_en), 32'd1);
    chk("lat_din", bus.din, 32'hA5A5_0001);
    chk("lat_addr", 32'(bus.addr), 32'd2);
    chk("lat_count0", 32'(bus.count), 32'd0);
    step();
    chk("lat_after_en", 32'(bus.din_en), 32'd0);
    chk("lat_after_din", bus.din, 32'd0);
    chk("lat_after_addr", 32'(bus.addr), 32'd0);

    // Head-of-line blocking: addr 0 busy blocks the addr 3 word behind it.
    bus.port_busy = 4'b0001;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h100;
    bus.in_addr   = 2'd0;
    step();
    bus.in_data = 32'h103;
    bus.in_addr = 2'd3;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hol_block", 32'(bus.hol_block), 32'd1);
      chk("hol_no_en", 32'(bus.din_en), 32'd0);
      chk("hol_count", 32'(bus.count), 32'd2);
      step();
    end
    bus.port_busy = 4'b0000;
    step();
    chk("hol_w0_en", 32'(bus.din_en), 32'd1);
    chk("hol_w0_din", bus.din, 32'h100);
    chk("hol_w0_addr", 32'(bus.addr), 32'd0);
    step();
    chk("hol_w1_en", 32'(bus.din_en), 32'd1);
    chk("hol_w1_din", bus.din, 32'h103);
    chk("hol_w1_addr", 32'(bus.addr), 32'd3);
    step();
    chk("hol_done_en", 32'(bus.din_en), 32'd0);
    chk("hol_done_cnt", 32'(bus.count), 32'd0);

    // Fill to DEPTH with all ports busy; a ninth beat must be held off.
    bus.port_busy = 4'b1111;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_data = 32'h200 + 32'(i);
      bus.in_addr = 2'(i);
      step();
    end
    bus.in_data = 32'h2FF;
    bus.in_addr = 2'd1;
    chk("full_count", 32'(bus.count), 32'd8);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    step();
    step();
    chk("full_held_cnt", 32'(bus.count), 32'd8);
    chk("full_hol", 32'(bus.hol_block), 32'd1);
    bus.in_valid  = 1'b0;
    bus.port_busy = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("full_drain_en", 32'(bus.din_en), 32'd1);
      chk("full_drain_din", bus.din, 32'h200 + 32'(i));
    end
    step();
    chk("full_end_en", 32'(bus.din_en), 32'd0);
    chk("full_end_cnt", 32'(bus.count), 32'd0);

    // Streaming 20 words: simultaneous push/pop at count 1, pointers wrap.
    for (int v = 1; v <= 20; v++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(v);
      bus.in_addr  = 2'(v % 4);
      step();
      chk("stream_count", 32'(bus.count), 32'd1);
      if (v > 1) begin
        chk("stream_en", 32'(bus.din_en), 32'd1);
        chk("stream_din", bus.din, 32'(v - 1));
      end
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_last", bus.din, 32'd20);
    chk("stream_cnt0", 32'(bus.count), 32'd0);
    step();

    // Reset while holding 5 words and offering a sixth.
    bus.port_busy = 4'b1111;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 32'h300 + 32'(i);
      bus.in_addr = 2'(i);
      step();
    end
    chk("rst5_count", 32'(bus.count), 32'd5);
    bus.in_data = 32'hDEAD;
    rst         = 1'b1;
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst5_cnt0", 32'(bus.count), 32'd0);
    chk("rst5_en", 32'(bus.din_en), 32'd0);
    chk("rst5_ready", 32'(bus.in_ready), 32'd1);
    chk("rst5_hol", 32'(bus.hol_block), 32'd0);
    bus.port_busy = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst5_quiet", 32'(bus.din_en), 32'd0);
    end

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/router_ingress_fifo.md
ROUTER_INGRESS_FIFO -- requirements
Module: router_ingress_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of payload word.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of 2, minimum 2.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers a beat.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept a beat.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  beat payload.
REQ-008 SHALL have port in_addr  input  2  beat destination port, 0..3.
REQ-009 SHALL have port port_busy  input  4  bit k high: destination k cannot take a word this cycle.
REQ-010 SHALL have port din  output  DATA_WIDTH  payload to router.
REQ-011 SHALL have port din_en  output  1  payload valid to router, one cycle per word.
REQ-012 SHALL have port addr  output  2  destination to router.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port hol_block  output  1  head entry present but blocked by port_busy.

Function
REQ-015 SHALL store {in_addr, in_data} pairs in arrival order in a circular buffer with wrapping read/write pointers.
REQ-016 SHALL drive in_ready = (count < DEPTH), combinationally from registered count only; no same-cycle pop bypass when full.
REQ-017 SHALL accept (push) a beat at a rising edge exactly when in_valid && in_ready.
REQ-018 SHALL pop the head at a rising edge exactly when count > 0 && !port_busy[head addr].
REQ-019 SHALL, on pop, register head data into din, head addr into addr, and set din_en = 1 for the following cycle.
REQ-020 SHALL, in any cycle following an edge without pop, hold din_en = 0, din = 0, addr = 0 (output zero when not driven).
REQ-021 SHALL give minimum latency 2 edges: beat pushed at edge E into empty FIFO, popped at edge E+1, din_en high during cycle after E+1.
REQ-022 SHALL sustain one pop per cycle, producing back-to-back din_en pulses while head destinations are not busy.
REQ-023 SHALL update count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-024 SHALL allow simultaneous push and pop at count = 1 and at count = DEPTH-1 with correct ordering and no data loss.
REQ-025 SHALL wrap pointers from DEPTH-1 to 0 with no gap or duplicate entry.
REQ-026 SHALL be strictly in-order: a blocked head blocks all later entries, regardless of their destinations.
REQ-027 SHALL drive hol_block = (count > 0) && port_busy[head addr], combinationally.
REQ-028 SHALL never push when count = DEPTH and never pop when count = 0; in_valid while !in_ready leaves state unchanged.
REQ-029 SHALL sample port_busy in the same cycle as the pop decision; busy asserting after pop does not cancel the issued word.

Reset
REQ-030 SHALL, when rst is high at a rising edge, clear pointers and count to 0, din_en to 0, din to 0, addr to 0, discarding all stored entries.
REQ-031 SHALL give rst priority over simultaneous push and pop at the same edge; no beat accepted at that edge.
REQ-032 SHALL drive in_ready = 1 and hol_block = 0 in the cycle after reset.
REQ-033 SHALL require no reset of storage array contents.

Verification
REQ-034 Bench SHALL cover: reset, push in_data=0xA5A5_0001 in_addr=2, port_busy=0 -> din_en=1, din=0xA5A50001, addr=2 exactly two edges after push; next cycle din_en=0, din=0, addr=0.
REQ-035 Bench SHALL cover: port_busy=4'b0001, push words addr 0 then addr 3 -> hol_block=1, no din_en; release port_busy -> addr 0 word then addr 3 word on consecutive cycles.
REQ-036 Bench SHALL cover: port_busy=4'b1111, push 8 beats -> count=8, in_ready=0, ninth beat held; release -> 8 din_en pulses in order, count returns 0.
REQ-037 Bench SHALL cover: continuous push/pop of 20 words (values 1..20, addr = value mod 4) -> pointers wrap twice, output sequence 1..20, count stays 1.
REQ-038 Bench SHALL cover: rst asserted at count=5 with in_valid=1 -> next cycle count=0, din_en=0, in_ready=1; none of the 5 words or the offered beat ever appear on din.
REQ-039 Bench SHALL check every cycle: din_en=0 implies din=0 and addr=0; count never exceeds DEPTH.
